bit_stream_serializer: RTL and testbench

Upstream feeder for the serial pattern-detector FSM. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. Each word is shifted out MSB-first as a one-bit-per-handshake serial stream, which drives the detector's serial input. It counts completed words for the bench and for status readout.

---
 rtl/ser_pkg.sv | 14 +
 rtl/ser_fifo.sv | 47 ++++
 rtl/bit_stream_serializer.sv | 160 ++++++++++++++++
 tb/tb_bit_stream_serializer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and constants for the bit-stream serializer and its FIFO.
package ser_pkg;

  localparam int unsigned WORDS_SENT_W = 16;
  localparam logic [WORDS_SENT_W-1:0] WORDS_SENT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    GAP    = 2'd2,
    PARITY = 2'd3
  } ser_state_e;

endpackage : ser_pkg

// File: rtl/ser_fifo.sv
// Small synchronous FIFO, power-of-two depth, extra pointer bit separates full from empty.
module ser_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count_c   = wr_ptr - rd_ptr;
  assign rd_data_c = mem[rd_ptr[AW-1:0]];
  assign do_push   = push && !full_c;
  assign do_pop    = pop && !empty_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule : ser_fifo

// File: rtl/bit_stream_serializer.sv
// Buffers parallel words and shifts them out MSB-first over a bit valid/ready handshake.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module bit_stream_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned IDLE_GAP   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic                    bit_out,
  output logic                    bit_valid,
  input  logic                    bit_ready,
  output logic                    busy,
  output logic [WORDS_SENT_W-1:0] words_sent
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]  GAP_LOAD = (IDLE_GAP == 0) ? 4'd0 : 4'(IDLE_GAP - 1);

  ser_state_e              state, state_nx;
  logic [WIDTH-1:0]        shift_reg, shift_nx;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_nx;
  logic [3:0]              gap_cnt, gap_cnt_nx;
  logic [WORDS_SENT_W-1:0] words_sent_nx;
  logic                    bit_out_nx, bit_valid_nx, busy_nx;
  logic                    word_done, load;
  logic                    push_c, pop_c;
  logic [WIDTH-1:0]        fifo_rd_data_c;
  logic                    fifo_full_c, fifo_empty_c;
  logic [CW-1:0]           fifo_count_c, fifo_count_nx;
`ifdef SER_PARITY_EN
  logic                    parity_q, parity_nx;
`endif

  assign word_ready = !fifo_full_c;
  assign push_c     = word_valid && !fifo_full_c;

  ser_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .wr_data   (word_in),
    .pop       (pop_c),
    .rd_data_c (fifo_rd_data_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c),
    .count_c   (fifo_count_c)
  );

  // Next state, shifter and registered-output next values.
  always_comb begin
    state_nx      = state;
    shift_nx      = shift_reg;
    bit_cnt_nx    = bit_cnt;
    gap_cnt_nx    = gap_cnt;
    words_sent_nx = words_sent;
    word_done     = 1'b0;
    load          = 1'b0;
    pop_c         = 1'b0;
`ifdef SER_PARITY_EN
    parity_nx     = parity_q;
`endif

    unique case (state)
      IDLE: if (!fifo_empty_c) load = 1'b1;
      SHIFT: begin
        if (bit_ready) begin
          shift_nx   = {shift_reg[WIDTH-2:0], 1'b0};
          bit_cnt_nx = bit_cnt - CNT_W'(1);
          if (bit_cnt == '0) begin
`ifdef SER_PARITY_EN
            state_nx = PARITY;
`else
            word_done = 1'b1;
`endif
          end
        end
      end
`ifdef SER_PARITY_EN
      PARITY: if (bit_ready) word_done = 1'b1;
`endif
      // Final gap cycle hands straight to the next word so the gap is exactly IDLE_GAP cycles.
      GAP: begin
        if (gap_cnt == '0) begin
          if (!fifo_empty_c) load = 1'b1;
          else               state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt - 4'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    if (word_done) begin
      if (words_sent != WORDS_SENT_MAX) words_sent_nx = words_sent + WORDS_SENT_W'(1);
      if (IDLE_GAP != 0) begin
        gap_cnt_nx = GAP_LOAD;
        state_nx   = GAP;
      end else if (!fifo_empty_c) begin
        load = 1'b1;
      end else begin
        state_nx = IDLE;
      end
    end

    if (load) begin
      pop_c      = 1'b1;
      shift_nx   = fifo_rd_data_c;
      bit_cnt_nx = CNT_W'(WIDTH - 1);
      state_nx   = SHIFT;
`ifdef SER_PARITY_EN
      parity_nx  = ^fifo_rd_data_c;
`endif
    end

    fifo_count_nx = fifo_count_c + CW'(push_c) - CW'(pop_c);
    bit_valid_nx  = (state_nx == SHIFT) || (state_nx == PARITY);
    bit_out_nx    = 1'b0;
    if (state_nx == SHIFT) bit_out_nx = shift_nx[WIDTH-1];
`ifdef SER_PARITY_EN
    if (state_nx == PARITY) bit_out_nx = parity_nx;
`endif
    busy_nx = (state_nx != IDLE) || (fifo_count_nx != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      words_sent <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      shift_reg  <= shift_nx;
      bit_cnt    <= bit_cnt_nx;
      gap_cnt    <= gap_cnt_nx;
      words_sent <= words_sent_nx;
      bit_out    <= bit_out_nx;
      bit_valid  <= bit_valid_nx;
      busy       <= busy_nx;
`ifdef SER_PARITY_EN
      parity_q   <= parity_nx;
`endif
    end
  end

endmodule : bit_stream_serializer

// File: tb/tb_bit_stream_serializer.sv
// Directed bench: one instance with IDLE_GAP=0, one with IDLE_GAP=3.
module tb_bit_stream_serializer;

`ifdef SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  g0_word_in, g3_word_in;
  logic        g0_word_valid, g3_word_valid, g0_word_ready, g3_word_ready;
  logic        g0_bit_out, g3_bit_out, g0_bit_valid, g3_bit_valid;
  logic        g0_bit_ready, g3_bit_ready, g0_busy, g3_busy;
  logic [15:0] g0_words_sent, g3_words_sent;

  bit_stream_serializer #(.WIDTH(8), .FIFO_DEPTH(2), .IDLE_GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .word_in(g0_word_in), .word_valid(g0_word_valid),
    .word_ready(g0_word_ready), .bit_out(g0_bit_out), .bit_valid(g0_bit_valid),
    .bit_ready(g0_bit_ready), .busy(g0_busy), .words_sent(g0_words_sent));

  bit_stream_serializer #(.WIDTH(8), .FIFO_DEPTH(2), .IDLE_GAP(3)) u_g3 (
    .clk(clk), .reset(reset), .word_in(g3_word_in), .word_valid(g3_word_valid),
    .word_ready(g3_word_ready), .bit_out(g3_bit_out), .bit_valid(g3_bit_valid),
    .bit_ready(g3_bit_ready), .busy(g3_busy), .words_sent(g3_words_sent));

  int n_cmp = 0;
  int n_err = 0;

  // Monitor: consumed bits shift into acc*, per-cycle bit_valid into vh*.
  logic [63:0] acc0 = '0, acc3 = '0;
  int          nb0 = 0, nb3 = 0;
  logic        vh0[$];
  logic        vh3[$];

  always @(posedge clk) begin
    vh0.push_back(g0_bit_valid);
    vh3.push_back(g3_bit_valid);
    if (g0_bit_valid && g0_bit_ready) begin acc0 = {acc0[62:0], g0_bit_out}; nb0++; end
    if (g3_bit_valid && g3_bit_ready) begin acc3 = {acc3[62:0], g3_bit_out}; nb3++; end
  end

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_bits;
    logic       exp_par;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ew(input logic [7:0] w, input logic p);
    logic [63:0] r;
    r = {56'd0, w};
    if (NB == 9) r = {r[62:0], p};
    return r;
  endfunction

  function automatic logic [63:0] tail(input logic [63:0] a, input int n);
    logic [63:0] m;
    m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    return a & m;
  endfunction

  task automatic push(input bit sel, input logic [7:0] w);
    int k = 0;
    if (sel) begin g3_word_in = w; g3_word_valid = 1'b1; end
    else     begin g0_word_in = w; g0_word_valid = 1'b1; end
    while (!(sel ? g3_word_ready : g0_word_ready) && k < 100) begin tick(); k++; end
    check("push_ready", 64'(sel ? g3_word_ready : g0_word_ready), 64'd1);
    tick();
    if (sel) g3_word_valid = 1'b0;
    else     g0_word_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int k = 0;
    while ((sel ? g3_busy : g0_busy) && k < 300) begin tick(); k++; end
    check("idle_wait", 64'(sel ? g3_busy : g0_busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[4];
    int          exp_sent0;
    int          start, base, k, run, ones, gap, phase;
    logic [63:0] e;

    tbl[0] = '{8'hB0, 8'b1011_0000, 1'b1};
    tbl[1] = '{8'hA5, 8'b1010_0101, 1'b0};
    tbl[2] = '{8'h07, 8'b0000_0111, 1'b1};
    tbl[3] = '{8'h81, 8'b1000_0001, 1'b0};

    reset = 1'b1;
    g0_word_in = '0; g0_word_valid = 1'b0; g0_bit_ready = 1'b1;
    g3_word_in = '0; g3_word_valid = 1'b0; g3_bit_ready = 1'b1;
    tick(); tick();
    check("rst_bit_valid", 64'(g0_bit_valid), 64'd0);
    check("rst_bit_out", 64'(g0_bit_out), 64'd0);
    check("rst_busy", 64'(g0_busy), 64'd0);
    check("rst_words_sent", 64'(g0_words_sent), 64'd0);
    reset = 1'b0;
    tick();
    check("rst_word_ready", 64'(g0_word_ready), 64'd1);
    exp_sent0 = 0;

    // Single words: latency, stream, increment on the final bit, busy drop.
    for (int i = 0; i < 4; i++) begin
      start = nb0;
      push(1'b0, tbl[i].word);
      check("lat_valid_low", 64'(g0_bit_valid), 64'd0);
      check("lat_busy", 64'(g0_busy), 64'd1);
      tick();
      check("lat_valid_high", 64'(g0_bit_valid), 64'd1);
      check("first_bit", 64'(g0_bit_out), 64'(tbl[i].exp_bits[7]));
      k = 0;
      while (nb0 - start < NB - 1 && k < 50) begin tick(); k++; end
      check("before_last_sent", 64'(g0_words_sent), 64'(exp_sent0));
      wait_idle(1'b0);
      exp_sent0++;
      check("stream", tail(acc0, nb0 - start), ew(tbl[i].exp_bits, tbl[i].exp_par));
      check("nbits", 64'(nb0 - start), 64'(NB));
      check("words_sent", 64'(g0_words_sent), 64'(exp_sent0));
      check("done_valid", 64'(g0_bit_valid), 64'd0);
    end

    // Back-to-back words with no gap: continuous stream.
    start = nb0;
    base  = vh0.size();
    push(1'b0, 8'hA5);
    push(1'b0, 8'h3C);
    wait_idle(1'b0);
    exp_sent0 += 2;
    e = (ew(8'hA5, 1'b0) << NB) | ew(8'h3C, 1'b0);
    check("b2b_stream", tail(acc0, nb0 - start), e);
    run = 0;
    phase = 0;
    for (int i = base; i < vh0.size(); i++) begin
      if (phase == 0 && vh0[i]) phase = 1;
      if (phase == 1) begin
        if (vh0[i]) run++;
        else phase = 2;
      end
    end
    check("b2b_no_bubble", 64'(run), 64'(2 * NB));
    check("b2b_words_sent", 64'(g0_words_sent), 64'(exp_sent0));

    // Backpressure: fill FIFO behind a stalled shifter, hold a fourth word.
    start = nb0;
    g0_bit_ready = 1'b0;
    push(1'b0, 8'hFF);
    push(1'b0, 8'h11);
    push(1'b0, 8'h22);
    check("full_word_ready", 64'(g0_word_ready), 64'd0);
    g0_word_in = 8'h33;
    g0_word_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_bit_out", 64'(g0_bit_out), 64'd1);
      check("stall_bit_valid", 64'(g0_bit_valid), 64'd1);
      check("stall_word_ready", 64'(g0_word_ready), 64'd0);
    end
    check("stall_no_consume", 64'(nb0 - start), 64'd0);
    g0_bit_ready = 1'b1;
    push(1'b0, 8'h33);
    wait_idle(1'b0);
    exp_sent0 += 4;
    e = ew(8'hFF, 1'b0);
    e = (e << NB) | ew(8'h11, 1'b0);
    e = (e << NB) | ew(8'h22, 1'b0);
    e = (e << NB) | ew(8'h33, 1'b0);
    check("bp_stream", tail(acc0, nb0 - start), e);
    check("bp_words_sent", 64'(g0_words_sent), 64'(exp_sent0));

    // Reset after three bits of a word; nothing resumes, next word starts clean.
    start = nb0;
    push(1'b0, 8'hB0);
    k = 0;
    while (nb0 - start < 3 && k < 50) begin tick(); k++; end
    reset = 1'b1;
    g0_bit_ready = 1'b0;
    tick();
    check("mid_rst_bits", 64'(nb0 - start), 64'd3);
    check("mid_rst_valid", 64'(g0_bit_valid), 64'd0);
    check("mid_rst_sent", 64'(g0_words_sent), 64'd0);
    check("mid_rst_busy", 64'(g0_busy), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", 64'(g0_word_ready), 64'd1);
    check("post_rst_valid", 64'(g0_bit_valid), 64'd0);
    check("post_rst_busy", 64'(g0_busy), 64'd0);
    g0_bit_ready = 1'b1;
    start = nb0;
    push(1'b0, 8'h80);
    wait_idle(1'b0);
    check("post_rst_stream", tail(acc0, nb0 - start), ew(8'h80, 1'b1));
    check("post_rst_sent", 64'(g0_words_sent), 64'd1);

    // IDLE_GAP=3 instance: exactly three invalid cycles between words.
    start = nb3;
    base  = vh3.size();
    push(1'b1, 8'hC3);
    push(1'b1, 8'h5A);
    wait_idle(1'b1);
    ones = 0;
    gap = 0;
    phase = 0;
    for (int i = base; i < vh3.size(); i++) begin
      if (phase == 0) begin
        if (vh3[i]) begin
          ones++;
          if (ones == NB) phase = 1;
        end
      end else if (phase == 1) begin
        if (!vh3[i]) gap++;
        else phase = 2;
      end
    end
    check("gap_cycles", 64'(gap), 64'd3);
    e = (ew(8'hC3, 1'b0) << NB) | ew(8'h5A, 1'b0);
    check("gap_stream", tail(acc3, nb3 - start), e);
    check("gap_words_sent", 64'(g3_words_sent), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bit_stream_serializer
